interr_ctrl: RTL and testbench

//  Interrupt controller directly upstream of the control unit. Captures external IRQ edges,

---
 rtl/interr_ctrl.sv | 118 +++++++++++
 tb/tb_interr_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/interr_ctrl.sv
// Interrupt controller: edge capture, mask, fixed priority, single in-service tracking.
// Define INTERR_SYNC_EN to put a two-flop synchronizer on irq ahead of edge capture.
module interr_ctrl #(
  parameter int                N_IRQ      = 4,
  parameter int                ID_W       = 2,
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 10'h3C0,
  parameter int                VEC_STRIDE = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_data,
  input  logic              we_istack,
  input  logic              s_finish_interr,
  output logic              s_interruption,
  output logic [ADDR_W-1:0] irq_vector,
  output logic [ID_W-1:0]   irq_id,
  output logic              in_service,
  output logic [N_IRQ-1:0]  pending_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   irq_prev;
  logic [N_IRQ-1:0]   mask;
  logic [N_IRQ-1:0]   irq_cap;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   clr;
  logic [N_IRQ-1:0]   eligible;
  logic [ID_W-1:0]    sel;
  logic [ADDR_W-1:0]  sel_vec;
  logic               accept;

`ifdef INTERR_SYNC_EN
  logic [N_IRQ-1:0] sync1;
  logic [N_IRQ-1:0] sync2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

  assign irq_cap = sync2;
`else
  assign irq_cap = irq;
`endif

  assign rise     = irq_cap & ~irq_prev;
  assign eligible = pending & ~mask;
  assign accept   = (state == REQ) && we_istack;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_clr
      assign clr[gi] = accept && (irq_id == ID_W'(gi));
    end
  endgenerate

  // Lowest index wins: scan downward so the last hit is the highest priority.
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  assign sel_vec = VEC_BASE + ADDR_W'(sel) * ADDR_W'(VEC_STRIDE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending    <= '0;
      irq_prev   <= '0;
      mask       <= '1;
      irq_id     <= '0;
      irq_vector <= VEC_BASE;
    end else begin
      irq_prev <= irq_cap;
      // A fresh edge on the line being accepted survives the clear.
      pending  <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_data;

      case (state)
        IDLE: begin
          if (eligible != '0) begin
            state      <= REQ;
            irq_id     <= sel;
            irq_vector <= sel_vec;
          end
        end
        REQ: begin
          if (we_istack)
            state <= SERVICE;
          else if (mask[irq_id] || !pending[irq_id])
            state <= IDLE;
        end
        SERVICE: begin
          if (s_finish_interr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_interruption = (state == REQ);
  assign in_service     = (state == SERVICE);
  assign pending_o      = pending;

endmodule

// File: tb/tb_interr_ctrl.sv
// Directed bench for interr_ctrl: per-cycle model comparison plus literal checkpoints.
module tb_interr_ctrl;

`ifdef INTERR_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] irq = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_data = '0;
  logic       we_istack = 1'b0;
  logic       s_finish_interr = 1'b0;
  logic       s_interruption;
  logic [9:0] irq_vector;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] pending_o;

  int tests = 0;
  int fails = 0;

  interr_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .irq            (irq),
    .mask_we        (mask_we),
    .mask_data      (mask_data),
    .we_istack      (we_istack),
    .s_finish_interr(s_finish_interr),
    .s_interruption (s_interruption),
    .irq_vector     (irq_vector),
    .irq_id         (irq_id),
    .in_service     (in_service),
    .pending_o      (pending_o)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = waiting, 1 = requesting, 2 = handler running.
  int         m_phase = 0;
  logic [3:0] m_pend = '0;
  logic [3:0] m_mask = '1;
  logic [3:0] m_prev = '0;
  logic [3:0] m_p0 = '0;
  logic [3:0] m_p1 = '0;
  logic [1:0] m_id = '0;

  function automatic logic [9:0] vec_of(input logic [1:0] id);
    return 10'h3C0 + 10'(id) * 10'd4;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] samp;
    logic [3:0] fresh;
    logic [3:0] cleared;
    logic [3:0] ready;
    if (!reset_n) begin
      m_phase = 0; m_pend = '0; m_mask = '1; m_prev = '0;
      m_p0 = '0; m_p1 = '0; m_id = '0;
    end else begin
      samp  = (SL == 2) ? m_p1 : irq;
      m_p1  = m_p0;
      m_p0  = irq;
      fresh = samp & ~m_prev;
      m_prev = samp;
      cleared = (m_phase == 1 && we_istack) ? (4'b0001 << m_id) : 4'b0000;
      ready = m_pend & ~m_mask;
      if (m_phase == 0) begin
        if (ready != 0) begin
          for (int i = 3; i >= 0; i--) if (ready[i]) m_id = 2'(i);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (we_istack) m_phase = 2;
        else if (m_mask[m_id] || !m_pend[m_id]) m_phase = 0;
      end else begin
        if (s_finish_interr) m_phase = 0;
      end
      m_pend = (m_pend & ~cleared) | fresh;
      if (mask_we) m_mask = mask_data;
    end
  end

  always @(negedge clk) begin
    tests++;
    if (s_interruption !== (m_phase == 1) || in_service !== (m_phase == 2) ||
        irq_id !== m_id || irq_vector !== vec_of(m_id) || pending_o !== m_pend) begin
      fails++;
      $display("FAIL cycle_model t=%0t got sint=%b insvc=%b id=%0d vec=%h pend=%b required sint=%b insvc=%b id=%0d vec=%h pend=%b",
               $time, s_interruption, in_service, irq_id, irq_vector, pending_o,
               (m_phase == 1), (m_phase == 2), m_id, vec_of(m_id), m_pend);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept_finish();
    we_istack = 1'b1; cyc(1); we_istack = 1'b0;
    s_finish_interr = 1'b1; cyc(1); s_finish_interr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sint"}, 32'(s_interruption), 0);
    check({tag, "_insvc"}, 32'(in_service), 0);
    check({tag, "_id"}, 32'(irq_id), 0);
    check({tag, "_vec"}, 32'(irq_vector), 32'h3C0);
    check({tag, "_pend"}, 32'(pending_o), 0);
  endtask

  initial begin
    cyc(2);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    mask_we = 1'b1; mask_data = 4'b0000; cyc(1); mask_we = 1'b0;

    // Single line 2: latency and vector.
    irq = 4'b0100; cyc(1 + SL);
    check("t1_pend", 32'(pending_o), 32'b0100);
    check("t1_sint_early", 32'(s_interruption), 0);
    cyc(1);
    check("t1_sint", 32'(s_interruption), 1);
    check("t1_id", 32'(irq_id), 2);
    check("t1_vec", 32'(irq_vector), 32'h3C8);
    we_istack = 1'b1; cyc(1); we_istack = 1'b0;
    check("t1_insvc", 32'(in_service), 1);
    check("t1_pend_clr", 32'(pending_o), 0);
    irq = 4'b0101; cyc(2 + SL);
    check("t1_held_pend", 32'(pending_o), 32'b0001);
    check("t1_held_sint", 32'(s_interruption), 0);
    s_finish_interr = 1'b1; cyc(1); s_finish_interr = 1'b0;
    check("t1_idle_insvc", 32'(in_service), 0);
    check("t1_idle_sint", 32'(s_interruption), 0);
    cyc(1);
    check("t1_next_id", 32'(irq_id), 0);
    check("t1_next_vec", 32'(irq_vector), 32'h3C0);
    accept_finish();
    irq = 4'b0000; cyc(3 + SL);

    // Lines 3 and 1 together; simultaneous accept and finish.
    irq = 4'b1010; cyc(2 + SL);
    check("t2_id", 32'(irq_id), 1);
    check("t2_vec", 32'(irq_vector), 32'h3C4);
    we_istack = 1'b1; s_finish_interr = 1'b1; cyc(1); we_istack = 1'b0;
    check("t2_accept_only", 32'(in_service), 1);
    cyc(1); s_finish_interr = 1'b0;
    check("t2_finished", 32'(s_interruption), 0);
    cyc(1);
    check("t2_second_id", 32'(irq_id), 3);
    check("t2_second_vec", 32'(irq_vector), 32'h3CC);
    accept_finish();
    irq = 4'b0000; cyc(3 + SL);
    we_istack = 1'b1; s_finish_interr = 1'b1; cyc(2);
    we_istack = 1'b0; s_finish_interr = 1'b0;
    check("idle_ignore", 32'({s_interruption, in_service}), 0);

    // Masked line still latches; unmask triggers request one cycle later.
    mask_we = 1'b1; mask_data = 4'b1111; cyc(1); mask_we = 1'b0;
    irq = 4'b0001; cyc(3 + SL);
    check("t3_pend", 32'(pending_o), 32'b0001);
    check("t3_sint", 32'(s_interruption), 0);
    mask_we = 1'b1; mask_data = 4'b0000; cyc(1); mask_we = 1'b0;
    check("t3_sint_wait", 32'(s_interruption), 0);
    cyc(1);
    check("t3_sint_req", 32'(s_interruption), 1);
    check("t3_id", 32'(irq_id), 0);
    accept_finish();
    irq = 4'b0000; cyc(3 + SL);

    // Masking the latched line while requesting drops back to idle.
    irq = 4'b0010; cyc(2 + SL);
    check("t4_id", 32'(irq_id), 1);
    mask_we = 1'b1; mask_data = 4'b0010; cyc(1); mask_we = 1'b0;
    check("t4_still_req", 32'(s_interruption), 1);
    cyc(1);
    check("t4_dropped", 32'(s_interruption), 0);
    check("t4_pend", 32'(pending_o), 32'b0010);
    mask_we = 1'b1; mask_data = 4'b0000; cyc(1); mask_we = 1'b0;
    cyc(1);
    check("t4_rereq", 32'({s_interruption, irq_id}), 32'b101);
    accept_finish();
    irq = 4'b0000; cyc(3 + SL);

    // Higher priority arriving in REQ does not replace the latched id.
    irq = 4'b1000; cyc(2 + SL);
    irq = 4'b1001; cyc(2 + SL);
    check("t5_keep_id", 32'(irq_id), 3);
    we_istack = 1'b1; cyc(1); we_istack = 1'b0;
    check("t5_pend", 32'(pending_o), 32'b0001);
    s_finish_interr = 1'b1; cyc(1); s_finish_interr = 1'b0;
    cyc(1);
    check("t5_next_id", 32'(irq_id), 0);
    accept_finish();
    irq = 4'b0000; cyc(3 + SL);

    // Re-edge on the line being accepted survives the clear.
    irq = 4'b0100; cyc(1); irq = 4'b0000; cyc(1 + SL);
    check("t6_id", 32'(irq_id), 2);
    we_istack = 1'b1; irq = 4'b0100; cyc(1); we_istack = 1'b0;
    check("t6_insvc", 32'(in_service), 1);
`ifndef INTERR_SYNC_EN
    check("t6_pend_kept", 32'(pending_o), 32'b0100);
`endif
    cyc(SL);
    s_finish_interr = 1'b1; cyc(1); s_finish_interr = 1'b0;
    cyc(1);
    check("t6_rereq", 32'({s_interruption, irq_id}), 32'b110);
    accept_finish();
    irq = 4'b0000; cyc(3 + SL);

    // Reset while a handler runs.
    irq = 4'b0001; cyc(2 + SL);
    we_istack = 1'b1; cyc(1); we_istack = 1'b0;
    check("t7_insvc", 32'(in_service), 1);
    reset_n = 1'b0; cyc(1);
    check_reset_outputs("t7_reset");
    reset_n = 1'b1;
    irq = 4'b0011; cyc(3 + SL);
    check("t7_masked_pend", 32'(pending_o), 32'b0011);
    check("t7_masked_sint", 32'(s_interruption), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
